// File: rtl/fpga_link_tx_replay.sv
// fpga_link_tx_replay: buffered inter-FPGA link transmitter with burst replay.
// Words written by the local producer stay in the buffer until the peer
// acknowledges the burst that carried them. A dropped rdy_in or a stalled
// handshake rewinds the read cursor and replays the burst, up to MAX_RETRY times.
module fpga_link_tx_replay #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 512,
   parameter int CNT_W        = 10,
   parameter int TIMEOUT      = 1024,
   parameter int MAX_RETRY    = 3,
   parameter int DONE_STRETCH = 3,
   parameter int RETRY_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [CNT_W-1:0]  fifo_level,
   output logic              overflow,
   input  logic              start,
   input  logic [CNT_W-1:0]  send_count,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic              req_out,
   input  logic              rdy_in,
   input  logic              ack_in,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              send_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(DONE_STRETCH + 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_SEND     = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_RETRY    = 3'd4
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [DATA_W-1:0]    mem_r [DEPTH];
   // Pointers are CNT_W wide so that wr_ptr - base_ptr yields the level
   // directly; the low AW bits address the buffer.
   logic [CNT_W-1:0]     wr_ptr_r, wr_ptr_nxt_s;
   logic [CNT_W-1:0]     base_ptr_r, base_ptr_nxt_s;
   logic [CNT_W-1:0]     rd_ptr_r, rd_ptr_nxt_s;
   logic [CNT_W-1:0]     count_r, count_nxt_s;
   logic [CNT_W-1:0]     rem_r, rem_nxt_s;
   logic [CNT_W-1:0]     level_nxt_s;
   logic [RETRY_W-1:0]   retry_r, retry_nxt_s;
   logic [TW-1:0]        to_cnt_r;
   logic [SW-1:0]        stretch_r;
   logic [DATA_W-1:0]    tx_data_r;
   logic [CNT_W-1:0]     fifo_level_r;
   logic                 fifo_full_r, fifo_empty_r, overflow_r;
   logic                 busy_r, done_r, fail_r, req_r, tx_valid_r, send_done_r;
   logic                 issue_s, commit_s, fail_s, timeout_s;
   logic                 wr_acc_s, ovf_s, sd_load_s, sd_clear_s;

   // Next-state, pointer and handshake decisions for the burst controller.
   always_comb begin
      state_nxt_s    = state_r;
      rd_ptr_nxt_s   = rd_ptr_r;
      base_ptr_nxt_s = base_ptr_r;
      count_nxt_s    = count_r;
      rem_nxt_s      = rem_r;
      retry_nxt_s    = retry_r;
      issue_s        = 1'b0;
      commit_s       = 1'b0;
      fail_s         = 1'b0;
      timeout_s      = (to_cnt_r == TW'(TIMEOUT - 1));
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if ((send_count == CNT_W'(0)) || (send_count > fifo_level_r)) begin
                  fail_s = 1'b1;
               end else begin
                  count_nxt_s  = send_count;
                  rem_nxt_s    = send_count;
                  rd_ptr_nxt_s = base_ptr_r;
                  retry_nxt_s  = RETRY_W'(0);
                  state_nxt_s  = ST_WAIT_RDY;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT_RDY: begin
            if (rdy_in) begin
               state_nxt_s = ST_SEND;
            end else if (timeout_s) begin
               state_nxt_s = ST_RETRY;
            end else begin
               state_nxt_s = ST_WAIT_RDY;
            end
         end
         ST_SEND: begin
            if (rdy_in) begin
               issue_s      = 1'b1;
               rd_ptr_nxt_s = rd_ptr_r + CNT_W'(1);
               rem_nxt_s    = rem_r - CNT_W'(1);
               if (rem_r == CNT_W'(1)) begin
                  state_nxt_s = ST_WAIT_ACK;
               end else begin
                  state_nxt_s = ST_SEND;
               end
            end else if (timeout_s) begin
               state_nxt_s = ST_RETRY;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_WAIT_ACK: begin
            // ack wins over a simultaneous rdy drop
            if (ack_in) begin
               commit_s       = 1'b1;
               base_ptr_nxt_s = rd_ptr_r;
               state_nxt_s    = ST_IDLE;
            end else if (!rdy_in || timeout_s) begin
               state_nxt_s = ST_RETRY;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         ST_RETRY: begin
            if (retry_r < RETRY_W'(MAX_RETRY)) begin
               retry_nxt_s  = retry_r + RETRY_W'(1);
               rd_ptr_nxt_s = base_ptr_r;
               rem_nxt_s    = count_r;
               state_nxt_s  = ST_WAIT_RDY;
            end else begin
               fail_s      = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Write acceptance: a full buffer still takes a word when a commit frees space.
   always_comb begin
      wr_acc_s     = wr_en && (!fifo_full_r || commit_s);
      ovf_s        = wr_en && fifo_full_r && !commit_s;
      wr_ptr_nxt_s = wr_acc_s ? (wr_ptr_r + CNT_W'(1)) : wr_ptr_r;
      level_nxt_s  = wr_ptr_nxt_s - base_ptr_nxt_s;
      sd_load_s    = (state_r == ST_WAIT_ACK) && tx_valid_r;
      sd_clear_s   = (state_nxt_s == ST_RETRY) || (ack_in && (state_r != ST_WAIT_ACK));
   end

   // Buffer storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

   // State, pointers, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         wr_ptr_r     <= CNT_W'(0);
         base_ptr_r   <= CNT_W'(0);
         rd_ptr_r     <= CNT_W'(0);
         count_r      <= CNT_W'(0);
         rem_r        <= CNT_W'(0);
         retry_r      <= RETRY_W'(0);
         to_cnt_r     <= TW'(0);
         stretch_r    <= SW'(0);
         tx_data_r    <= DATA_W'(0);
         fifo_level_r <= CNT_W'(0);
         fifo_full_r  <= 1'b0;
         fifo_empty_r <= 1'b1;
         overflow_r   <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         fail_r       <= 1'b0;
         req_r        <= 1'b0;
         tx_valid_r   <= 1'b0;
         send_done_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         wr_ptr_r     <= wr_ptr_nxt_s;
         base_ptr_r   <= base_ptr_nxt_s;
         rd_ptr_r     <= rd_ptr_nxt_s;
         count_r      <= count_nxt_s;
         rem_r        <= rem_nxt_s;
         retry_r      <= retry_nxt_s;
         fifo_level_r <= level_nxt_s;
         fifo_full_r  <= (level_nxt_s == CNT_W'(DEPTH));
         fifo_empty_r <= (level_nxt_s == CNT_W'(0));
         overflow_r   <= ovf_s;
         busy_r       <= (state_nxt_s != ST_IDLE);
         done_r       <= commit_s;
         fail_r       <= fail_s;
         req_r        <= (state_nxt_s == ST_WAIT_RDY) || (state_nxt_s == ST_SEND) ||
                         (state_nxt_s == ST_WAIT_ACK);
         tx_valid_r   <= issue_s;
         if (issue_s) begin
            tx_data_r <= mem_r[rd_ptr_r[AW-1:0]];
         end else begin
            tx_data_r <= tx_data_r;
         end
         // no-progress counter: restarts on every state change and every issued word
         if ((state_nxt_s != state_r) || issue_s) begin
            to_cnt_r <= TW'(0);
         end else if ((state_r == ST_WAIT_RDY) || (state_r == ST_SEND) ||
                      (state_r == ST_WAIT_ACK)) begin
            to_cnt_r <= to_cnt_r + TW'(1);
         end else begin
            to_cnt_r <= TW'(0);
         end
         // send_done stretch begins the cycle after the last tx_valid
         if (sd_clear_s) begin
            stretch_r   <= SW'(0);
            send_done_r <= 1'b0;
         end else if (sd_load_s) begin
            stretch_r   <= SW'(DONE_STRETCH - 1);
            send_done_r <= 1'b1;
         end else if (stretch_r != SW'(0)) begin
            stretch_r   <= stretch_r - SW'(1);
            send_done_r <= 1'b1;
         end else begin
            stretch_r   <= SW'(0);
            send_done_r <= 1'b0;
         end
      end
   end

   assign fifo_full  = fifo_full_r;
   assign fifo_empty = fifo_empty_r;
   assign fifo_level = fifo_level_r;
   assign overflow   = overflow_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign fail       = fail_r;
   assign retry_cnt  = retry_r;
   assign req_out    = req_r;
   assign tx_data    = tx_data_r;
   assign tx_valid   = tx_valid_r;
   assign send_done  = send_done_r;

endmodule

// File: tb/tb_fpga_link_tx_replay.sv
// Directed bench for fpga_link_tx_replay: expected link words are queued when a
// burst is started and compared as tx_valid beats appear.
module tb_fpga_link_tx_replay;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 512;
   localparam int CNT_W   = 10;
   localparam int TIMEOUT = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              fifo_full, fifo_empty, overflow;
   logic [CNT_W-1:0]  fifo_level;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  send_count = '0;
   logic              busy, done, fail;
   logic [1:0]        retry_cnt;
   logic              req_out;
   logic              rdy_in = 1'b0;
   logic              ack_in = 1'b0;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid, send_done;

   int checks = 0;
   int errors = 0;
   int tx_seen, done_seen, fail_seen, sd_cycles, run, max_run;
   logic [DATA_W-1:0] exp_q[$];

   fpga_link_tx_replay dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
      .overflow(overflow), .start(start), .send_count(send_count), .busy(busy),
      .done(done), .fail(fail), .retry_cnt(retry_cnt), .req_out(req_out),
      .rdy_in(rdy_in), .ack_in(ack_in), .tx_data(tx_data), .tx_valid(tx_valid),
      .send_done(send_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      tx_seen = 0; done_seen = 0; fail_seen = 0; sd_cycles = 0; run = 0; max_run = 0;
   endtask

   // one clock; outputs sampled 1 time unit after the rising edge
   task automatic tick();
      logic [DATA_W-1:0] e;
      @(posedge clk); #1;
      if (tx_valid === 1'b1) begin
         tx_seen++;
         run++;
         if (run > max_run) max_run = run;
         if (exp_q.size() == 0) begin
            check("tx_unexpected", 64'(tx_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", 64'(tx_data), 64'(e));
         end
      end else begin
         run = 0;
      end
      if (done === 1'b1) done_seen++;
      if (fail === 1'b1) fail_seen++;
      if (send_done === 1'b1) sd_cycles++;
   endtask

   task automatic write_words(input logic [DATA_W-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1;
         wr_data = base + DATA_W'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + DATA_W'(i));
   endtask

   task automatic start_burst(input int cnt);
      start = 1'b1;
      send_count = CNT_W'(cnt);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_send_done(input string tag);
      int n = 0;
      while (send_done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check(tag, 64'(send_done), 64'd1);
   endtask

   task automatic ack_and_settle();
      tick();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int n;
      int retry_obs;

      // reset values
      repeat (3) tick();
      check("rst_fifo_empty", 64'(fifo_empty), 64'd1);
      check("rst_fifo_full", 64'(fifo_full), 64'd0);
      check("rst_fifo_level", 64'(fifo_level), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_req_out", 64'(req_out), 64'd0);
      check("rst_outs", 64'({tx_valid, send_done, done, fail, overflow, retry_cnt}), 64'd0);
      rst = 1'b0;
      tick();

      // 1: clean burst of 8
      clr_stats();
      write_words(32'h100, 8);
      check("t1_level_before", 64'(fifo_level), 64'd8);
      push_exp(32'h100, 8);
      rdy_in = 1'b1;
      start_burst(8);
      wait_send_done("t1_send_done");
      ack_and_settle();
      check("t1_tx_count", 64'(tx_seen), 64'd8);
      check("t1_consecutive", 64'(max_run), 64'd8);
      check("t1_send_done_cycles", 64'(sd_cycles), 64'd3);
      check("t1_done_pulses", 64'(done_seen), 64'd1);
      check("t1_level_after", 64'(fifo_level), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // 2: rdy drop in WAIT_ACK forces one replay
      clr_stats();
      write_words(32'h100, 8);
      push_exp(32'h100, 8);
      push_exp(32'h100, 8);
      start_burst(8);
      wait_send_done("t2_first_attempt");
      rdy_in = 1'b0;
      tick();
      check("t2_retry_req_low", 64'(req_out), 64'd0);
      rdy_in = 1'b1;
      tick();
      check("t2_retry_cnt", 64'(retry_cnt), 64'd1);
      wait_send_done("t2_second_attempt");
      ack_and_settle();
      check("t2_tx_count", 64'(tx_seen), 64'd16);
      check("t2_done_pulses", 64'(done_seen), 64'd1);
      check("t2_retry_after", 64'(retry_cnt), 64'd1);
      check("t2_level_after", 64'(fifo_level), 64'd0);

      // 3: rdy held low -> timeouts exhaust retries
      clr_stats();
      write_words(32'h100, 8);
      rdy_in = 1'b0;
      start_burst(8);
      n = 0;
      retry_obs = 0;
      while (fail !== 1'b1 && n < 5000) begin
         tick();
         n++;
         if (busy === 1'b1 && req_out === 1'b0) retry_obs++;
      end
      check("t3_fail_latency", 64'(n), 64'(4 * (TIMEOUT + 1)));
      check("t3_retry_passes", 64'(retry_obs), 64'd4);
      check("t3_retry_cnt", 64'(retry_cnt), 64'd3);
      check("t3_busy", 64'(busy), 64'd0);
      check("t3_level", 64'(fifo_level), 64'd8);
      check("t3_no_tx", 64'(tx_seen), 64'd0);
      clr_stats();
      push_exp(32'h100, 8);
      rdy_in = 1'b1;
      start_burst(8);
      check("t3_retry_cleared", 64'(retry_cnt), 64'd0);
      wait_send_done("t3_resend");
      ack_and_settle();
      check("t3_resend_tx", 64'(tx_seen), 64'd8);
      check("t3_resend_level", 64'(fifo_level), 64'd0);

      // 4: rejected starts
      clr_stats();
      write_words(32'h200, 3);
      start_burst(5);
      check("t4_fail_over", 64'(fail), 64'd1);
      check("t4_req_over", 64'(req_out), 64'd0);
      tick();
      check("t4_fail_pulse_end", 64'(fail), 64'd0);
      start_burst(0);
      check("t4_fail_zero", 64'(fail), 64'd1);
      check("t4_req_zero", 64'(req_out), 64'd0);
      tick();
      check("t4_fail_count", 64'(fail_seen), 64'd2);
      check("t4_busy", 64'(busy), 64'd0);

      // 5: fill, overflow, commit with concurrent write
      clr_stats();
      write_words(32'h1000, DEPTH - 3);
      check("t5_full", 64'(fifo_full), 64'd1);
      check("t5_level_full", 64'(fifo_level), 64'(DEPTH));
      wr_en = 1'b1;
      wr_data = 32'hDEAD;
      tick();
      wr_en = 1'b0;
      check("t5_overflow", 64'(overflow), 64'd1);
      check("t5_full_after_ovf", 64'(fifo_full), 64'd1);
      tick();
      check("t5_overflow_end", 64'(overflow), 64'd0);
      push_exp(32'h200, 3);
      push_exp(32'h1000, 1);
      start_burst(4);
      wait_send_done("t5_send_done");
      tick();
      ack_in = 1'b1;
      wr_en = 1'b1;
      wr_data = 32'hABC;
      tick();
      ack_in = 1'b0;
      wr_en = 1'b0;
      check("t5_level_commit_write", 64'(fifo_level), 64'd509);
      check("t5_no_overflow", 64'(overflow), 64'd0);
      repeat (3) tick();
      check("t5_done", 64'(done_seen), 64'd1);

      // 6: reset in the middle of SEND
      clr_stats();
      push_exp(32'h1001, 3);
      start_burst(8);
      n = 0;
      while (tx_seen < 3 && n < 50) begin
         tick();
         n++;
      end
      check("t6_three_words", 64'(tx_seen), 64'd3);
      rst = 1'b1;
      tick();
      check("t6_req_out", 64'(req_out), 64'd0);
      check("t6_tx_valid", 64'(tx_valid), 64'd0);
      check("t6_fifo_empty", 64'(fifo_empty), 64'd1);
      check("t6_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_link_tx_replay.md
Name: fpga_link_tx_replay

Overview:
- Parametrised next-generation FPGA-to-FPGA link transmitter.
- An internal single-clock buffer holds words written by the local process. On start, the block sends a burst of send_count words to the peer over the req/rdy/ack handshake.
- Buffer words are released only when the peer acks the burst. A dropped rdy or a timeout rewinds the read pointer and replays the burst, up to MAX_RETRY times.
- Sits between the local producer and the inter-FPGA pins.

Parameters:
- DATA_W, 32: link and buffer word width.
- DEPTH, 512: buffer depth in words; power of two, at least 4.
- CNT_W, 10: width of send_count and fifo_level; must satisfy 2^CNT_W > DEPTH.
- TIMEOUT, 1024: consecutive no-progress cycles before a retry.
- MAX_RETRY, 3: replays allowed before the burst is declared failed.
- DONE_STRETCH, 3: length of the send_done pulse in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write wr_data into the buffer.
- wr_data  in  DATA_W  producer word.
- fifo_full  out  1  fifo_level == DEPTH.
- fifo_empty  out  1  fifo_level == 0.
- fifo_level  out  CNT_W  count of uncommitted (not yet acked) words.
- overflow  out  1  one-cycle pulse when wr_en arrives while full; the word is dropped.
- start  in  1  begin a burst (sampled in IDLE only).
- send_count  in  CNT_W  burst length, latched at accept.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on ack.
- fail  out  1  one-cycle pulse on start rejection or retry exhaustion.
- retry_cnt  out  2+  replays used by the current burst.
- req_out  out  1  request to peer.
- rdy_in  in  1  peer ready.
- ack_in  in  1  peer acknowledge.
- tx_data  out  DATA_W  link data.
- tx_valid  out  1  tx_data valid this cycle.
- send_done  out  1  end-of-burst marker, DONE_STRETCH cycles long.

Behaviour:
- Reset: clears all pointers and counters and moves to IDLE. All outputs go to 0 except fifo_empty, which goes to 1. Reset mid-burst discards buffer contents.

Buffer pointers:
- wr_ptr advances on each accepted write.
- base_ptr marks the oldest uncommitted word.
- rd_ptr is the replay cursor.
- fifo_level = wr_ptr - base_ptr, in modulo arithmetic.
- Writes are accepted in every state.
- Simultaneous write and commit: level becomes level + 1 - count.

IDLE:
- req_out=0.
- start with send_count==0, or send_count > fifo_level: fail pulse next cycle, stay in IDLE.
- Otherwise: latch count, set rd_ptr=base_ptr, clear retry_cnt, go to WAIT_RDY.

WAIT_RDY:
- req_out=1.
- rdy_in=1: go to SEND and clear the timeout counter.

SEND:
- req_out=1.
- Each cycle with rdy_in=1:
  - next edge: tx_valid=1, tx_data=mem[rd_ptr].
  - rd_ptr increments and remaining decrements.
- Each cycle with rdy_in=0: tx_valid=0 next edge (pause).
- When the last word is issued: go to WAIT_ACK. send_done is high for DONE_STRETCH cycles starting with the cycle after the last tx_valid.

WAIT_ACK:
- ack_in=1: base_ptr=rd_ptr (commit), done pulse, req_out=0, go to IDLE.
- rdy_in=0 without ack: go to RETRY.
- If ack_in and a rdy_in drop occur in the same cycle, ack wins.

Timeout:
- The counter clears on state entry and on each issued word, and increments otherwise in WAIT_RDY, SEND and WAIT_ACK.
- Reaching TIMEOUT: go to RETRY.

RETRY (1 cycle):
- req_out=0, tx_valid=0, send_done cleared.
- If retry_cnt < MAX_RETRY: retry_cnt++, rd_ptr=base_ptr, remaining=count, go to WAIT_RDY.
- Else: fail pulse, go to IDLE. The words stay in the buffer, uncommitted.

Other rules:
- ack_in outside WAIT_ACK is ignored, but it clears the send_done stretch.
- tx_valid is 0 in every state except the cycle after a SEND issue.

Test Plan:
- Write 8 words 0x100..0x107, start with send_count=8, rdy held high, ack 2 cycles after the last word: tx_valid for 8 consecutive cycles carrying 0x100..0x107 in order; send_done high for 3 cycles; done pulses once; fifo_level goes 8 -> 0.
- Same burst, with rdy_in dropped in WAIT_ACK on the first attempt and ack on the second: 0x100..0x107 sent twice; retry_cnt=1; done pulses once; fifo_level=0.
- rdy_in held low after start: every TIMEOUT+1 cycles the block passes through RETRY; after the 4th expiry fail pulses, busy=0, fifo_level=8, and the next start resends from 0x100.
- start with send_count=5 and fifo_level=3, and separately with send_count=0: fail pulses, req_out stays 0.
- Fill to DEPTH=512, then write again: overflow pulses, fifo_full=1. A burst of 4 acked while wr_en is high gives fifo_level=509 the next cycle.
- Assert rst mid-SEND after 3 words: next cycle req_out=0, tx_valid=0, fifo_empty=1, busy=0.
